// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state encoding and default geometry for the median frame collector
package median_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_READOUT = 2'd2
  } state_e;

  localparam int DEF_OUT_WIDTH  = 6;
  localparam int DEF_OUT_HEIGHT = 6;
  localparam int ADDR_W = $clog2(DEF_OUT_WIDTH * DEF_OUT_HEIGHT);
  localparam int X_W    = $clog2(DEF_OUT_WIDTH);
  localparam int Y_W    = $clog2(DEF_OUT_HEIGHT);

endpackage

// File: rtl/frame_raster_counter.sv
// rtl/frame_raster_counter.sv - raster x/y counter with clear, enable, wrap and last-pixel flag
module frame_raster_counter #(
  parameter int COLS = 6,
  parameter int ROWS = 6,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic x_end, y_end;

  assign x_end = (x == XW'(COLS - 1));
  assign y_end = (y == YW'(ROWS - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/median_frame_collector.sv
// rtl/median_frame_collector.sv - captures one filtered frame into a buffer and streams it to a reader
module median_frame_collector
  import median_pkg::*;
#(
  parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
  parameter int OUT_HEIGHT      = DEF_OUT_HEIGHT,
  parameter int PIXEL_WIDTH     = 8,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [PIXEL_WIDTH-1:0]        pix_data,
  input  logic                          flush,
  input  logic                          rd_start,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [PIXEL_WIDTH-1:0]        rd_data,
  output logic [$clog2(OUT_WIDTH)-1:0]  rd_x,
  output logic [$clog2(OUT_HEIGHT)-1:0] rd_y,
  output logic                          rd_last,
  output logic                          frame_ready,
  output logic                          overflow,
  output logic [FRAME_CNT_WIDTH-1:0]    frame_count
);

  localparam int XW    = $clog2(OUT_WIDTH);
  localparam int YW    = $clog2(OUT_HEIGHT);
  localparam int DEPTH = OUT_WIDTH * OUT_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  state_e state_q, state_d;

  logic          wr_en, wr_clr, wr_last;
  logic          rd_clr, rd_adv, rd_load, rd_at_last;
  logic          drop, done, hs;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [PIXEL_WIDTH-1:0] mem [DEPTH];

  function automatic logic [AW-1:0] raster_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(OUT_WIDTH) + AW'(x);
  endfunction

  frame_raster_counter #(.COLS(OUT_WIDTH), .ROWS(OUT_HEIGHT), .XW(XW), .YW(YW)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (wr_clr),
    .en   (wr_en),
    .x    (wr_x),
    .y    (wr_y),
    .last (wr_last)
  );

  frame_raster_counter #(.COLS(OUT_WIDTH), .ROWS(OUT_HEIGHT), .XW(XW), .YW(YW)) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (rd_clr),
    .en   (rd_adv),
    .x    (rd_x),
    .y    (rd_y),
    .last (rd_at_last)
  );

  assign wr_addr     = raster_addr(wr_x, wr_y);
  assign rd_addr     = raster_addr(rd_x, rd_y);
  assign hs          = rd_valid && rd_ready;
  assign rd_last     = rd_valid && rd_at_last;
  assign frame_ready = (state_q != ST_COLLECT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  // flush overrides everything; a pixel arriving with it is discarded silently
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_clr  = 1'b0;
    rd_clr  = 1'b0;
    rd_load = 1'b0;
    rd_adv  = 1'b0;
    drop    = 1'b0;
    done    = 1'b0;
    if (flush) begin
      state_d = ST_COLLECT;
      wr_clr  = 1'b1;
      rd_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (pix_valid) begin
            wr_en = 1'b1;
            if (wr_last) state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          drop = pix_valid;
          if (rd_start) begin
            state_d = ST_READOUT;
            rd_clr  = 1'b1;
            rd_load = 1'b1;
          end
        end
        ST_READOUT: begin
          drop = pix_valid;
          if (hs) begin
            if (rd_at_last) begin
              done    = 1'b1;
              state_d = ST_COLLECT;
              wr_clr  = 1'b1;
              rd_clr  = 1'b1;
            end else begin
              rd_adv = 1'b1;
            end
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pix_data;
  end

  // raster order makes the next pixel simply the following address
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (done) frame_count <= frame_count + 1'b1;
      if (flush || done) rd_valid <= 1'b0;
      else if (rd_load)  rd_valid <= 1'b1;
      if (rd_load)     rd_data <= mem[0];
      else if (rd_adv) rd_data <= mem[rd_addr + 1'b1];
    end
  end

endmodule

// File: tb/tb_median_frame_collector.sv
// tb/tb_median_frame_collector.sv - self-checking bench for median_frame_collector
module tb_median_frame_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       flush = 1'b0;
  logic       rd_start = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] rd_x;
  logic [2:0] rd_y;
  logic       rd_last;
  logic       frame_ready;
  logic       overflow;
  logic [7:0] frame_count;

  int total = 0;
  int passed = 0;
  int exp_frame [36];
  int exp_fc = 0;
  int exp_ovf = 0;

  always #5 clk = ~clk;

  median_frame_collector dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .flush       (flush),
    .rd_start    (rd_start),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_last     (rd_last),
    .frame_ready (frame_ready),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 36; i++) exp_frame[i] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_frame(input int n, input int lo);
    for (int i = lo; i < lo + n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(exp_frame[i]);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_x"}, rd_x, 0);
    check({tag, "_rd_y"}, rd_y, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input int mode);
    int idx;
    int cyc;
    logic r;
    logic [3:0] pat;
    pat = 4'b1001;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 36 && cyc < 400) begin
      check("rd_valid_held", rd_valid, 1);
      check("rd_data", rd_data, 32'(exp_frame[idx] & 255));
      check("rd_x", rd_x, idx % 6);
      check("rd_y", rd_y, idx / 6);
      check("rd_last", rd_last, (idx == 35) ? 1 : 0);
      check("frame_ready_rd", frame_ready, 1);
      check("overflow_rd", overflow, exp_ovf);
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = pat[3 - (cyc % 4)];
      else r = 1'($urandom_range(0, 1));
      rd_ready = r;
      tick();
      if (r) idx++;
      cyc++;
    end
    rd_ready = 1'b0;
    check("drain_count", idx, 36);
    exp_fc = (exp_fc + 1) % 256;
    check("post_rd_valid", rd_valid, 0);
    check("post_frame_ready", frame_ready, 0);
    check("post_frame_count", frame_count, exp_fc);
    check("post_overflow", overflow, exp_ovf);
  endtask

  initial begin
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 36; i++) exp_frame[i] = i;
    fill_frame(35, 0);
    check("fill_ready_early", frame_ready, 0);
    fill_frame(1, 35);
    check("fill_ready", frame_ready, 1);
    drain(0);

    randomize_frame();
    fill_frame(20, 0);
    flush = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hAA;
    tick();
    flush = 1'b0;
    pix_valid = 1'b0;
    check("flush_frame_ready", frame_ready, 0);
    check("flush_overflow", overflow, 0);
    check("flush_frame_count", frame_count, exp_fc);
    for (int i = 0; i < 36; i++) exp_frame[i] = 8'h55;
    fill_frame(35, 0);
    check("flush_ready_early", frame_ready, 0);
    fill_frame(1, 35);
    check("flush_ready", frame_ready, 1);
    drain(2);

    randomize_frame();
    fill_frame(10, 0);
    rd_start = 1'b1;
    fill_frame(1, 10);
    rd_start = 1'b0;
    check("ign_start_valid", rd_valid, 0);
    check("ign_start_ready", frame_ready, 0);
    fill_frame(25, 11);
    check("ign_start_full", frame_ready, 1);
    drain(2);

    randomize_frame();
    fill_frame(36, 0);
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_data = 8'hAA;
      tick();
    end
    pix_valid = 1'b0;
    exp_ovf = 1;
    check("overflow_set", overflow, 1);
    drain(1);

    randomize_frame();
    fill_frame(36, 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    exp_fc = 0;
    exp_ovf = 0;

    for (int f = 0; f < 256; f++) begin
      randomize_frame();
      fill_frame(36, 0);
      drain(0);
    end
    check("wrap_frame_count", frame_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/median_frame_collector.md
Name: median_frame_collector

Overview:
- Downstream consumer of the median filter stage.
- Captures the filtered pixel stream (valid/data pulses, no backpressure) into an on-chip frame buffer of OUT_WIDTH x OUT_HEIGHT pixels in raster order.
- Once a full frame is held, a host-side reader drains it through a valid/ready stream. The block then rearms for the next frame.
- Pixels arriving while the buffer is busy are dropped and flagged.

Parameters:
- OUT_WIDTH, 6, filtered frame width in pixels (image width minus window size plus 1)
- OUT_HEIGHT, 6, filtered frame height in pixels
- PIXEL_WIDTH, 8, pixel data width in bits
- FRAME_CNT_WIDTH, 8, width of completed-frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_valid  in  1  filtered pixel strobe (driven from filter data_valid_out)
- pix_data  in  PIXEL_WIDTH  filtered pixel (driven from filter data_out)
- flush  in  1  synchronous abort: discard partial/held frame, return to COLLECT
- rd_start  in  1  request readout of the held frame
- rd_ready  in  1  reader accepts rd_data this cycle
- rd_valid  out  1  rd_data/rd_x/rd_y/rd_last valid
- rd_data  out  PIXEL_WIDTH  pixel being read
- rd_x  out  clog2(OUT_WIDTH)  column of rd_data
- rd_y  out  clog2(OUT_HEIGHT)  row of rd_data
- rd_last  out  1  high with the final pixel of the frame
- frame_ready  out  1  full frame held (state FULL)
- overflow  out  1  sticky: pixel dropped while not in COLLECT
- frame_count  out  FRAME_CNT_WIDTH  frames fully read out, wraps

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - All outputs 0.
  - State COLLECT.
  - Write and read counters 0.
  - Buffer contents don't-care.
- States: COLLECT, FULL, READOUT.
- COLLECT:
  - Each pix_valid writes pix_data at address wr_y*OUT_WIDTH+wr_x.
  - wr_x increments and wraps at OUT_WIDTH-1, which increments wr_y.
  - The write at (OUT_WIDTH-1, OUT_HEIGHT-1) moves the state to FULL next cycle; frame_ready=1 that cycle.
- FULL:
  - Holds the frame.
  - rd_start moves to READOUT with read counters at 0.
  - rd_start in any other state is ignored.
- READOUT:
  - The cycle after rd_start, rd_valid=1 with mem[0], rd_x=0, rd_y=0.
  - Outputs are registered. They hold stable while rd_valid && !rd_ready.
  - Each handshake (rd_valid && rd_ready) presents the next pixel the following cycle, so there are no bubbles while rd_ready stays high.
  - rd_last=1 exactly when rd_x=OUT_WIDTH-1 and rd_y=OUT_HEIGHT-1.
  - The handshake on the last pixel has these effects the next cycle:
    - rd_valid=0 and frame_ready=0.
    - frame_count+1 (wraps at 2^FRAME_CNT_WIDTH).
    - Write counters cleared; state COLLECT.
- Drop rule:
  - pix_valid in FULL or READOUT writes nothing and sets overflow, which stays 1 until rst.
  - pix_valid in the same cycle as the final COLLECT write is impossible, since there is one pixel per cycle.
  - The next cycle's pixel is dropped.
- flush:
  - Highest priority after rst.
  - Next cycle: COLLECT, all counters 0, rd_valid=0, frame_ready=0.
  - frame_count and overflow are unchanged.
  - A pix_valid in the flush cycle is discarded without setting overflow.
- Mid-operation rst behaves like flush and also clears frame_count and overflow.
- Coordinates use plain binary counters with explicit wrap compare, not modulo arithmetic. Address = y*OUT_WIDTH+x is computed at clog2(OUT_WIDTH*OUT_HEIGHT) bits.
- Latency:
  - Write: pixel visible in buffer 1 cycle after pix_valid.
  - Read: first rd_valid 1 cycle after rd_start.

Decomposition:
- Package median_pkg holds:
  - the state enum (COLLECT/FULL/READOUT) encoding constants;
  - clog2-derived width constants ADDR_W, X_W, Y_W.
- One natural sub-module: frame_raster_counter, an x/y counter with enable, clear, wrap and last flag. It is instantiated twice, once for writes and once for reads.
- The buffer is an inferred register array in the top.

Test Plan:
- Fill and drain:
  - Stimulus: 36 pix_valid with data = index (0..35), then rd_start, rd_ready=1.
  - Required: frame_ready rises 1 cycle after the 36th write; rd_data runs 0..35 on consecutive cycles; rd_last only on 35 (x=5, y=5); frame_count=1; state returns to COLLECT.
- Backpressure:
  - Stimulus: during readout, toggle rd_ready 1,0,0,1.
  - Required: rd_data/rd_x/rd_y stay stable while rd_ready=0; no pixel skipped or duplicated; sequence 0..35 intact.
- Overflow:
  - Stimulus: after a full frame, 3 extra pix_valid (values 0xAA).
  - Required: overflow=1 and stays high through readout; readout data unchanged (0..35).
- Flush:
  - Stimulus: flush after 20 writes, then write 36 pixels of value 0x55 and read out.
  - Required: frame_ready only after the 36 new writes; all 36 read values = 0x55; frame_count unchanged by flush.
- Ignored start and reset:
  - Stimulus: rd_start during COLLECT (10 pixels in).
  - Required: no rd_valid; collection continues normally.
  - Stimulus: rst asserted mid-readout.
  - Required: next cycle all outputs 0.
- Wrap:
  - Stimulus: 256 complete fill/drain cycles.
  - Required: frame_count wraps to 0.
